// File: rtl/dec_entry_to_bin.sv
// Decimal key-entry front end: collects up to two BCD digits, commits n = tens*10 + ones
// on enter, and echoes the entry in progress with a blink pulse for the display path.
module dec_entry_to_bin #(
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic [6:0] n,
  output logic       n_valid,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic       entering,
  output logic       blink_pulse,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_INC  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  // Multiply by ten as two shifts and an add; 99 fits in 7 bits.
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] t, input logic [3:0] o);
    logic [6:0] t7;
    t7 = {3'b000, t};
    return (t7 << 3) + (t7 << 1) + {3'b000, o};
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       ten_r, ten_s, one_r, one_s;
  logic [6:0]       n_r, n_s;
  logic             n_valid_r, n_valid_s;
  logic             err_r, err_s;
  logic             entering_r;
  logic             blink_r, blink_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  // Next-state and next-output logic; clear beats enter beats digit_valid.
  always_comb begin
    state_s   = state_r;
    ten_s     = ten_r;
    one_s     = one_r;
    n_s       = n_r;
    n_valid_s = 1'b0;
    err_s     = 1'b0;
    if (clear) begin
      state_s = S_IDLE;
      ten_s   = 4'd0;
      one_s   = 4'd0;
    end else if (enter) begin
      n_s       = bcd2_to_bin(ten_r, one_r);
      n_valid_s = 1'b1;
      state_s   = S_IDLE;
      ten_s     = 4'd0;
      one_s     = 4'd0;
    end else if (digit_valid) begin
      if (digit > 4'd9) begin
        err_s = 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            one_s   = digit;
            ten_s   = 4'd0;
            state_s = S_ONE;
          end
          S_ONE: begin
            ten_s   = one_r;
            one_s   = digit;
            state_s = S_TWO;
          end
          S_TWO: begin
            err_s = 1'b1;
          end
          default: begin
            state_s = S_IDLE;
            ten_s   = 4'd0;
            one_s   = 4'd0;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // Blink generator: idle holds it off, leaving idle restarts it high.
  always_comb begin
    cnt_s   = cnt_r;
    blink_s = blink_r;
    if (state_s == S_IDLE) begin
      cnt_s   = CNT_ZERO;
      blink_s = 1'b0;
    end else if (state_r == S_IDLE) begin
      cnt_s   = CNT_ZERO;
      blink_s = 1'b1;
    end else if (cnt_r == CNT_LAST) begin
      cnt_s   = CNT_ZERO;
      blink_s = ~blink_r;
    end else begin
      cnt_s   = cnt_r + CNT_INC;
      blink_s = blink_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      ten_r      <= 4'd0;
      one_r      <= 4'd0;
      n_r        <= 7'd0;
      n_valid_r  <= 1'b0;
      err_r      <= 1'b0;
      entering_r <= 1'b0;
      blink_r    <= 1'b0;
      cnt_r      <= CNT_ZERO;
    end else begin
      state_r    <= state_s;
      ten_r      <= ten_s;
      one_r      <= one_s;
      n_r        <= n_s;
      n_valid_r  <= n_valid_s;
      err_r      <= err_s;
      entering_r <= (state_s != S_IDLE);
      blink_r    <= blink_s;
      cnt_r      <= cnt_s;
    end
  end

  assign n           = n_r;
  assign n_valid     = n_valid_r;
  assign ten         = ten_r;
  assign one         = one_r;
  assign entering    = entering_r;
  assign blink_pulse = blink_r;
  assign err         = err_r;

endmodule

// File: tb/tb_dec_entry_to_bin.sv
// Directed bench for dec_entry_to_bin with a short blink period so toggling is observable.
module tb_dec_entry_to_bin;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic [6:0] n;
  logic       n_valid;
  logic [3:0] ten;
  logic [3:0] one;
  logic       entering;
  logic       blink_pulse;
  logic       err;

  int errs   = 0;
  int checks = 0;

  dec_entry_to_bin #(.BLINK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .n(n), .n_valid(n_valid), .ten(ten),
    .one(one), .entering(entering), .blink_pulse(blink_pulse), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; digit_valid = 1'b0; digit = 4'd0; enter = 1'b0; clear = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rst_n", n, 0);
    chk("rst_nvalid", n_valid, 0);
    chk("rst_ten", ten, 0);
    chk("rst_one", one, 0);
    chk("rst_entering", entering, 0);
    chk("rst_blink", blink_pulse, 0);
    chk("rst_err", err, 0);

    // 4, 7, enter -> 47
    key(4'd4);
    chk("d4_one", one, 4);
    chk("d4_ten", ten, 0);
    chk("d4_entering", entering, 1);
    chk("d4_blink", blink_pulse, 1);
    key(4'd7);
    chk("d7_ten", ten, 4);
    chk("d7_one", one, 7);
    press_enter();
    chk("e47_n", n, 47);
    chk("e47_nvalid", n_valid, 1);
    chk("e47_ten", ten, 0);
    chk("e47_one", one, 0);
    chk("e47_entering", entering, 0);
    chk("e47_blink", blink_pulse, 0);
    tick();
    chk("e47_nvalid_clr", n_valid, 0);
    chk("e47_n_hold", n, 47);

    // 9, 9, 3 (rejected), enter -> 99
    key(4'd9);
    key(4'd9);
    chk("d99_ten", ten, 9);
    chk("d99_one", one, 9);
    key(4'd3);
    chk("d3_err", err, 1);
    chk("d3_one", one, 9);
    chk("d3_ten", ten, 9);
    tick();
    chk("d3_err_clr", err, 0);
    press_enter();
    chk("e99_n", n, 99);
    chk("e99_nvalid", n_valid, 1);
    chk("e99_err", err, 0);

    // 5, clear, enter in idle -> 0
    key(4'd5);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_entering", entering, 0);
    chk("clr_one", one, 0);
    chk("clr_n_hold", n, 99);
    chk("clr_nvalid", n_valid, 0);
    press_enter();
    chk("eidle_n", n, 0);
    chk("eidle_nvalid", n_valid, 1);

    // clear + enter + digit together: clear wins silently
    key(4'd2);
    clear = 1'b1; enter = 1'b1; digit_valid = 1'b1; digit = 4'd3;
    tick();
    clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    chk("all3_entering", entering, 0);
    chk("all3_nvalid", n_valid, 0);
    chk("all3_err", err, 0);
    chk("all3_one", one, 0);
    chk("all3_n", n, 0);

    // invalid digit 12 in idle, then 6, enter -> 6
    key(4'd12);
    chk("d12_err", err, 1);
    chk("d12_entering", entering, 0);
    chk("d12_one", one, 0);
    key(4'd6);
    chk("d6_one", one, 6);
    press_enter();
    chk("e6_n", n, 6);
    chk("e6_nvalid", n_valid, 1);

    // blink: high for 4 cycles, low for 4, ...
    key(4'd1);
    chk("blink_0", blink_pulse, 1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("blink_%0d", i), blink_pulse, ((i / 4) % 2 == 0) ? 1 : 0);
    end
    chk("blink_entering", entering, 1);

    // reset mid-entry with enter asserted: no commit
    rst_n = 1'b0; enter = 1'b1;
    tick();
    enter = 1'b0;
    chk("mrst_n", n, 0);
    chk("mrst_nvalid", n_valid, 0);
    chk("mrst_entering", entering, 0);
    chk("mrst_blink", blink_pulse, 0);
    chk("mrst_one", one, 0);
    chk("mrst_err", err, 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_nvalid_after", n_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
